// File: rtl/vga_timing_gen.sv
// Two-set VGA raster timing generator; mode_sel takes effect only at a frame boundary.
// Optional frame counter output when VGA_TG_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int A_H_ACT  = 800,
  parameter int A_H_FP   = 56,
  parameter int A_H_SYNC = 120,
  parameter int A_H_BP   = 64,
  parameter int A_V_ACT  = 600,
  parameter int A_V_FP   = 37,
  parameter int A_V_SYNC = 6,
  parameter int A_V_BP   = 23,
  parameter bit A_HS_POL = 1'b1,
  parameter bit A_VS_POL = 1'b1,
  parameter int A_DIV    = 1,
  parameter int B_H_ACT  = 640,
  parameter int B_H_FP   = 16,
  parameter int B_H_SYNC = 96,
  parameter int B_H_BP   = 48,
  parameter int B_V_ACT  = 480,
  parameter int B_V_FP   = 10,
  parameter int B_V_SYNC = 2,
  parameter int B_V_BP   = 33,
  parameter bit B_HS_POL = 1'b0,
  parameter bit B_VS_POL = 1'b0,
  parameter int B_DIV    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode_sel,
  output logic        pix_en,
  output logic [11:0] col,
  output logic [10:0] row,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        mode_active
`ifdef VGA_TG_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int A_H_TOT = A_H_ACT + A_H_FP + A_H_SYNC + A_H_BP;
  localparam int A_V_TOT = A_V_ACT + A_V_FP + A_V_SYNC + A_V_BP;
  localparam int B_H_TOT = B_H_ACT + B_H_FP + B_H_SYNC + B_H_BP;
  localparam int B_V_TOT = B_V_ACT + B_V_FP + B_V_SYNC + B_V_BP;

  logic        set_b;
  logic        started;
  logic [3:0]  div_cnt;
  logic [3:0]  div_last;
  // Position that the next pix_en will present.
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        at_origin;
  logic        nxt_b;

  logic [11:0] h_act, hs_beg, hs_end, h_last;
  logic [10:0] v_act, vs_beg, vs_end, v_last;
  logic        hs_pol, vs_pol;

  assign div_last  = set_b ? 4'(B_DIV - 1) : 4'(A_DIV - 1);
  assign pix_en    = ~reset & (div_cnt == div_last);
  assign at_origin = (h_cnt == 12'd0) && (v_cnt == 11'd0);
  // The first origin after reset always stays in set A; later origins sample mode_sel.
  assign nxt_b     = (started && at_origin) ? mode_sel : set_b;

  always_comb begin
    h_act  = 12'(A_H_ACT);
    hs_beg = 12'(A_H_ACT + A_H_FP);
    hs_end = 12'(A_H_ACT + A_H_FP + A_H_SYNC - 1);
    h_last = 12'(A_H_TOT - 1);
    v_act  = 11'(A_V_ACT);
    vs_beg = 11'(A_V_ACT + A_V_FP);
    vs_end = 11'(A_V_ACT + A_V_FP + A_V_SYNC - 1);
    v_last = 11'(A_V_TOT - 1);
    hs_pol = A_HS_POL;
    vs_pol = A_VS_POL;
    if (nxt_b) begin
      h_act  = 12'(B_H_ACT);
      hs_beg = 12'(B_H_ACT + B_H_FP);
      hs_end = 12'(B_H_ACT + B_H_FP + B_H_SYNC - 1);
      h_last = 12'(B_H_TOT - 1);
      v_act  = 11'(B_V_ACT);
      vs_beg = 11'(B_V_ACT + B_V_FP);
      vs_end = 11'(B_V_ACT + B_V_FP + B_V_SYNC - 1);
      v_last = 11'(B_V_TOT - 1);
      hs_pol = B_HS_POL;
      vs_pol = B_VS_POL;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      set_b       <= 1'b0;
      started     <= 1'b0;
      div_cnt     <= 4'd0;
      h_cnt       <= 12'd0;
      v_cnt       <= 11'd0;
      col         <= 12'd0;
      row         <= 11'd0;
      visible     <= 1'b0;
      hsync       <= ~A_HS_POL;
      vsync       <= ~A_VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_active <= 1'b0;
    end else if (pix_en) begin
      div_cnt     <= 4'd0;
      set_b       <= nxt_b;
      started     <= 1'b1;
      col         <= h_cnt;
      row         <= v_cnt;
      visible     <= (h_cnt < h_act) && (v_cnt < v_act);
      hsync       <= (h_cnt >= hs_beg && h_cnt <= hs_end) ? hs_pol : ~hs_pol;
      vsync       <= (v_cnt >= vs_beg && v_cnt <= vs_end) ? vs_pol : ~vs_pol;
      line_start  <= (h_cnt == 12'd0);
      frame_start <= at_origin;
      mode_active <= nxt_b;
      if (h_cnt == h_last) begin
        h_cnt <= 12'd0;
        v_cnt <= (v_cnt == v_last) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

`ifdef VGA_TG_FRAME_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= 16'd0;
    end else if (pix_en && at_origin) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on shrunken rasters: arithmetic reference model checked every cycle,
// plus directed mode-switch / reset scenarios and literal period and sync-window checks.
module tb_vga_timing_gen;

  localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int A_VA = 6, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int A_DV = 1;
  localparam int B_HA = 6, B_HF = 1, B_HS = 2, B_HB = 3;
  localparam int B_VA = 4, B_VF = 2, B_VS = 1, B_VB = 2;
  localparam int B_DV = 2;

  int ha [2] = '{A_HA, B_HA};
  int hf [2] = '{A_HF, B_HF};
  int hs [2] = '{A_HS, B_HS};
  int hb [2] = '{A_HB, B_HB};
  int va [2] = '{A_VA, B_VA};
  int vf [2] = '{A_VF, B_VF};
  int vs [2] = '{A_VS, B_VS};
  int vb [2] = '{A_VB, B_VB};
  int dv [2] = '{A_DV, B_DV};
  bit hp [2] = '{1'b1, 1'b0};
  bit vp [2] = '{1'b1, 1'b0};

  logic        clock;
  logic        reset;
  logic        mode_sel;
  logic        pix_en;
  logic [11:0] col;
  logic [10:0] row;
  logic        visible, hsync, vsync, line_start, frame_start, mode_active;
`ifdef VGA_TG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_timing_gen #(
    .A_H_ACT(A_HA), .A_H_FP(A_HF), .A_H_SYNC(A_HS), .A_H_BP(A_HB),
    .A_V_ACT(A_VA), .A_V_FP(A_VF), .A_V_SYNC(A_VS), .A_V_BP(A_VB),
    .A_HS_POL(1'b1), .A_VS_POL(1'b1), .A_DIV(A_DV),
    .B_H_ACT(B_HA), .B_H_FP(B_HF), .B_H_SYNC(B_HS), .B_H_BP(B_HB),
    .B_V_ACT(B_VA), .B_V_FP(B_VF), .B_V_SYNC(B_VS), .B_V_BP(B_VB),
    .B_HS_POL(1'b0), .B_VS_POL(1'b0), .B_DIV(B_DV)
  ) dut (
    .clock(clock), .reset(reset), .mode_sel(mode_sel), .pix_en(pix_en),
    .col(col), .row(row), .visible(visible), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .mode_active(mode_active)
`ifdef VGA_TG_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int htot(input int s);
    return ha[s] + hf[s] + hs[s] + hb[s];
  endfunction

  function automatic int vtot(input int s);
    return va[s] + vf[s] + vs[s] + vb[s];
  endfunction

  // Model: e = clock edges since reset release; the current frame's origin was presented
  // at edge e0, and pixel n of that frame is presented at edge e0 + n*DIV.
  int e, e0, nxt, mset, fcnt_m;
  bit started_m;

  always @(posedge clock) begin
    if (reset) begin
      e = 0; e0 = dv[0]; nxt = dv[0]; mset = 0; started_m = 0; fcnt_m = 0;
    end else begin
      e++;
      if (e == nxt) begin
        if (started_m) mset = mode_sel ? 1 : 0;
        started_m = 1;
        e0 = e;
        nxt = e + htot(mset) * vtot(mset) * dv[mset];
        fcnt_m = (fcnt_m + 1) % 65536;
      end
    end
  end

  always @(negedge clock) begin
    logic [29:0] exp_v, act_v;
    int n, c, r;
    bit pe, hv, vv;
    act_v = {pix_en, col, row, visible, hsync, vsync, line_start, frame_start, mode_active};
    if (reset) begin
      exp_v = {1'b0, 12'd0, 11'd0, 1'b0, ~hp[0], ~vp[0], 3'b000};
    end else if (!started_m) begin
      pe = ((e + 1) % dv[0]) == 0;
      exp_v = {pe, 12'd0, 11'd0, 1'b0, ~hp[0], ~vp[0], 3'b000};
    end else begin
      n  = (e - e0) / dv[mset];
      c  = n % htot(mset);
      r  = n / htot(mset);
      pe = ((e + 1 - e0) % dv[mset]) == 0;
      hv = (c >= ha[mset] + hf[mset] && c <= ha[mset] + hf[mset] + hs[mset] - 1) ? hp[mset] : ~hp[mset];
      vv = (r >= va[mset] + vf[mset] && r <= va[mset] + vf[mset] + vs[mset] - 1) ? vp[mset] : ~vp[mset];
      exp_v = {pe, 12'(c), 11'(r), (c < ha[mset] && r < va[mset]), hv, vv,
               (c == 0), (c == 0 && r == 0), (mset == 1)};
    end
    check("cycle_outputs", 64'(act_v), 64'(exp_v));
`ifdef VGA_TG_FRAME_CNT_EN
    check("frame_cnt", 64'(frame_cnt), reset ? 64'd0 : 64'(fcnt_m));
`endif
  end

  // Observations of the DUT for literal checks.
  int cyc = 0, prev_cyc = 0, prev_mode = 0;
  bit prev_valid = 0, fs_prev = 0;
  int period [2] = '{-1, -1};
  int hs_min [2] = '{9999, 9999}, hs_max [2] = '{-1, -1};
  int vs_min [2] = '{9999, 9999}, vs_max [2] = '{-1, -1};
  int vis_7_5 = -1, vis_8_5 = -1, vis_0_6 = -1;

  always @(negedge clock) begin
    int m;
    cyc++;
    m = mode_active ? 1 : 0;
    if (reset) begin
      prev_valid = 0;
      fs_prev = 0;
    end else begin
      if (frame_start && !fs_prev) begin
        if (prev_valid) period[prev_mode] = cyc - prev_cyc;
        prev_cyc = cyc; prev_mode = m; prev_valid = 1;
      end
      fs_prev = frame_start;
      if (hsync == hp[m] && started_m) begin
        if (int'(col) < hs_min[m]) hs_min[m] = int'(col);
        if (int'(col) > hs_max[m]) hs_max[m] = int'(col);
      end
      if (vsync == vp[m] && started_m) begin
        if (int'(row) < vs_min[m]) vs_min[m] = int'(row);
        if (int'(row) > vs_max[m]) vs_max[m] = int'(row);
      end
      if (m == 0 && started_m) begin
        if (col == 12'd7 && row == 11'd5) vis_7_5 = int'(visible);
        if (col == 12'd8 && row == 11'd5) vis_8_5 = int'(visible);
        if (col == 12'd0 && row == 11'd6) vis_0_6 = int'(visible);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic wait_pos(input int c, input int r, input string name);
    bit hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step(1);
      if (!reset && int'(col) == c && int'(row) == r) hit = 1;
    end
    check(name, 64'(hit), 64'd1);
  endtask

  task automatic wait_fs(input string name);
    bit hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step(1);
      if (!reset && frame_start) hit = 1;
    end
    check(name, 64'(hit), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    mode_sel = 1'b0;
    step(4);
    check("reset_state", 64'({pix_en, col, row, hsync, vsync, mode_active}), 64'd0);
    reset = 1'b0;
    wait_fs("first_frame_start");
    check("first_origin", 64'({col, row, mode_active}), 64'd0);
`ifdef VGA_TG_FRAME_CNT_EN
    check("frame_cnt_first", 64'(frame_cnt), 64'd1);
`endif
    step(400);

    // Switch to set B at the next frame boundary.
    mode_sel = 1'b1;
    step(700);

    // Mid-frame glitch of mode_sel must not change the next frame.
    wait_pos(0, 2, "reach_b_row2");
    mode_sel = 1'b0;
    step(20);
    mode_sel = 1'b1;
    wait_fs("fs_after_glitch");
    check("mode_kept_b", 64'(mode_active), 64'd1);

    // Reset in the middle of a set-B frame.
    wait_pos(3, 2, "reach_b_3_2");
    reset = 1'b1;
    step(3);
    check("reset_mid_frame", 64'({pix_en, col, row, visible, mode_active}), 64'd0);
    reset = 1'b0;
    wait_fs("fs_after_reset");
    check("restart_set_a", 64'({col, row, mode_active}), 64'd0);
    step(300);

    for (int i = 0; i < 4000; i++) begin
      step(1);
      if ($urandom_range(0, 59) == 0) mode_sel = ~mode_sel;
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    mode_sel = 1'b0;
    step(700);

    check("period_a", 64'(period[0]), 64'd150);
    check("period_b", 64'(period[1]), 64'd216);
    check("hsync_a_first_col", 64'(hs_min[0]), 64'd10);
    check("hsync_a_last_col", 64'(hs_max[0]), 64'd12);
    check("vsync_a_first_row", 64'(vs_min[0]), 64'd7);
    check("vsync_a_last_row", 64'(vs_max[0]), 64'd8);
    check("hsync_b_first_col", 64'(hs_min[1]), 64'd7);
    check("hsync_b_last_col", 64'(hs_max[1]), 64'd8);
    check("vsync_b_first_row", 64'(vs_min[1]), 64'd6);
    check("vsync_b_last_row", 64'(vs_max[1]), 64'd6);
    check("visible_7_5", 64'(vis_7_5), 64'd1);
    check("visible_8_5", 64'(vis_8_5), 64'd0);
    check("visible_0_6", 64'(vis_0_6), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
